// File: rtl/univ_shift_reg.sv
// univ_shift_reg: parametrised 74194-style universal shift register.
// Modes (s): 00 hold, 01 shift right, 10 shift left, 11 parallel load, qualified by en.
// Asynchronous active-low clear (clr_n) forces q to RST_VAL.
// Optional feature: define UNIV_SHIFT_REG_ROTATE_EN to add the rot input.
// When rot=1, the shift modes recirculate the outgoing bit instead of taking dsr/dsl.
module univ_shift_reg #(
    parameter int               WIDTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             cp,
    input  logic             clr_n,
    input  logic             en,
    input  logic [1:0]       s,
    input  logic             dsr,
    input  logic             dsl,
    input  logic [WIDTH-1:0] d,
`ifdef UNIV_SHIFT_REG_ROTATE_EN
    input  logic             rot,
`endif
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn,
    output logic             sout_r,
    output logic             sout_l
);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_next;
    logic             w_srIn;
    logic             w_slIn;

    // Serial entry bits: in rotate mode these are the bits leaving the opposite end.
`ifdef UNIV_SHIFT_REG_ROTATE_EN
    assign w_srIn = rot ? r_q[0]       : dsr;
    assign w_slIn = rot ? r_q[WIDTH-1] : dsl;
`else
    assign w_srIn = dsr;
    assign w_slIn = dsl;
`endif

    // One 4:1 next-state mux and one D flip-flop per bit.
    // Bit WIDTH-1 takes w_srIn as its left neighbour; bit 0 takes w_slIn as its right neighbour.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic w_leftNb;
        logic w_rightNb;

        if (i == WIDTH-1) begin : g_top
            assign w_leftNb = w_srIn;
        end else begin : g_midTop
            assign w_leftNb = r_q[i+1];
        end

        if (i == 0) begin : g_bot
            assign w_rightNb = w_slIn;
        end else begin : g_midBot
            assign w_rightNb = r_q[i-1];
        end

        // Select the next value of this bit from the mode and the enable.
        always_comb begin
            w_next[i] = r_q[i];
            if (en) begin
                case (s)
                    2'b01:   w_next[i] = w_leftNb;
                    2'b10:   w_next[i] = w_rightNb;
                    2'b11:   w_next[i] = d[i];
                    default: w_next[i] = r_q[i];
                endcase
            end
        end

        // Bit storage cell; clear acts immediately and dominates the clock.
        always_ff @(posedge cp or negedge clr_n) begin
            if (!clr_n) begin
                r_q[i] <= RST_VAL[i];
            end else begin
                r_q[i] <= w_next[i];
            end
        end
    end

    assign q      = r_q;
    assign qn     = ~r_q;
    assign sout_r = r_q[0];
    assign sout_l = r_q[WIDTH-1];

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg with WIDTH=4 and RST_VAL=0.
// Expected values are hand-computed constants; the rotate vectors are built only when
// UNIV_SHIFT_REG_ROTATE_EN is defined.
module tb_univ_shift_reg;

    localparam int WIDTH = 4;

    logic             cp;
    logic             clr_n;
    logic             en;
    logic [1:0]       s;
    logic             dsr;
    logic             dsl;
    logic [WIDTH-1:0] d;
`ifdef UNIV_SHIFT_REG_ROTATE_EN
    logic             rot;
`endif
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qn;
    logic             sout_r;
    logic             sout_l;

    int assertCount = 0;
    int failCount   = 0;

    univ_shift_reg #(.WIDTH(WIDTH), .RST_VAL(4'b0000)) dut (
        .cp     (cp),
        .clr_n  (clr_n),
        .en     (en),
        .s      (s),
        .dsr    (dsr),
        .dsl    (dsl),
        .d      (d),
`ifdef UNIV_SHIFT_REG_ROTATE_EN
        .rot    (rot),
`endif
        .q      (q),
        .qn     (qn),
        .sout_r (sout_r),
        .sout_l (sout_l)
    );

    // Free-running clock, 10 time units per period.
    initial cp = 1'b0;
    always #5 cp = ~cp;

    // Count one comparison and report it if observed differs from expected.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assertCount++;
        if (obs !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Drive the control inputs at the falling edge, well away from the active edge.
    task automatic applyStimulus(input logic iEn, input logic [1:0] iS, input logic iDsr,
                                 input logic iDsl, input logic [WIDTH-1:0] iD);
        @(negedge cp);
        en  = iEn;
        s   = iS;
        dsr = iDsr;
        dsl = iDsl;
        d   = iD;
    endtask

    // Let one rising edge pass, then sample shortly afterwards.
    task automatic stepEdge();
        @(posedge cp);
        #1;
    endtask

    initial begin
        clr_n = 1'b0;
        en    = 1'b0;
        s     = 2'b00;
        dsr   = 1'b0;
        dsl   = 1'b0;
        d     = '0;
`ifdef UNIV_SHIFT_REG_ROTATE_EN
        rot   = 1'b0;
`endif
        #2;
        checkOutput("reset_q",      q,      4'b0000);
        checkOutput("reset_qn",     qn,     4'b1111);
        checkOutput("reset_sout_r", sout_r, 1'b0);
        checkOutput("reset_sout_l", sout_l, 1'b0);

        // Release clear asynchronously, then load 1010.
        @(negedge cp);
        clr_n = 1'b1;
        applyStimulus(1'b1, 2'b11, 1'b0, 1'b0, 4'b1010);
        stepEdge();
        checkOutput("load_1010", q, 4'b1010);

        // Clear pulse mid-cycle while cp is high: q clears before any edge.
        #2;
        clr_n = 1'b0;
        #1;
        checkOutput("midclr_q",  q,  4'b0000);
        checkOutput("midclr_qn", qn, 4'b1111);
        @(negedge cp);
        clr_n = 1'b1;

        // Parallel load 1011.
        applyStimulus(1'b1, 2'b11, 1'b0, 1'b0, 4'b1011);
        stepEdge();
        checkOutput("load_q",      q,      4'b1011);
        checkOutput("load_qn",     qn,     4'b0100);
        checkOutput("load_sout_l", sout_l, 1'b1);
        checkOutput("load_sout_r", sout_r, 1'b1);

        // Shift right three times with dsr=0.
        applyStimulus(1'b1, 2'b01, 1'b0, 1'b0, 4'b0000);
        stepEdge();
        checkOutput("shr1_q",      q,      4'b0101);
        checkOutput("shr1_sout_r", sout_r, 1'b1);
        stepEdge();
        checkOutput("shr2_q",      q,      4'b0010);
        checkOutput("shr2_sout_r", sout_r, 1'b0);
        stepEdge();
        checkOutput("shr3_q",      q,      4'b0001);
        checkOutput("shr3_sout_r", sout_r, 1'b1);

        // Shift left twice with dsl=1.
        applyStimulus(1'b1, 2'b10, 1'b0, 1'b1, 4'b0000);
        stepEdge();
        checkOutput("shl1_q", q, 4'b0011);
        stepEdge();
        checkOutput("shl2_q",      q,      4'b0111);
        checkOutput("shl2_sout_l", sout_l, 1'b0);

        // Enable low blocks a load.
        applyStimulus(1'b0, 2'b11, 1'b0, 1'b0, 4'b0000);
        stepEdge();
        checkOutput("en0_hold", q, 4'b0111);

        // Toggle d while cp is high with load selected; no edge, so q must not move.
        en = 1'b1;
        d  = 4'b1000;
        #1;
        d  = 4'b0101;
        #1;
        d  = 4'b1111;
        #1;
        checkOutput("dtoggle_q", q, 4'b0111);

        // Hold mode for five edges.
        applyStimulus(1'b1, 2'b00, 1'b1, 1'b1, 4'b1010);
        for (int i = 0; i < 5; i++) begin
            stepEdge();
            checkOutput($sformatf("hold%0d_q", i), q, 4'b0111);
        end

        // Mode changes take effect on the very edge that samples them.
        applyStimulus(1'b1, 2'b01, 1'b1, 1'b0, 4'b0000);
        stepEdge();
        checkOutput("modechg_shr_q", q, 4'b1011);
        applyStimulus(1'b1, 2'b10, 1'b0, 1'b0, 4'b0000);
        stepEdge();
        checkOutput("modechg_shl_q", q, 4'b0110);

        // Clear held across an edge during a shift sequence: the shift is discarded.
        applyStimulus(1'b1, 2'b01, 1'b1, 1'b0, 4'b0000);
        clr_n = 1'b0;
        stepEdge();
        checkOutput("clr_shift_q", q, 4'b0000);
        @(negedge cp);
        clr_n = 1'b1;
        applyStimulus(1'b1, 2'b11, 1'b0, 1'b0, 4'b1100);
        stepEdge();
        checkOutput("post_clr_load_q", q, 4'b1100);

`ifdef UNIV_SHIFT_REG_ROTATE_EN
        // Rotate right from 1000 four times, with dsr driven opposite to the wrapping bit.
        applyStimulus(1'b1, 2'b11, 1'b0, 1'b0, 4'b1000);
        stepEdge();
        applyStimulus(1'b1, 2'b01, 1'b1, 1'b1, 4'b0000);
        rot = 1'b1;
        stepEdge();
        checkOutput("rotr1_q", q, 4'b0100);
        stepEdge();
        checkOutput("rotr2_q", q, 4'b0010);
        stepEdge();
        checkOutput("rotr3_q", q, 4'b0001);
        stepEdge();
        checkOutput("rotr4_q", q, 4'b1000);

        // Rotate left from 1000 with dsl=0: the top bit wraps to bit 0.
        applyStimulus(1'b1, 2'b10, 1'b0, 1'b0, 4'b0000);
        stepEdge();
        checkOutput("rotl1_q", q, 4'b0001);

        // rot has no effect on parallel load.
        applyStimulus(1'b1, 2'b11, 1'b0, 1'b0, 4'b0110);
        stepEdge();
        checkOutput("rot_load_q", q, 4'b0110);
        rot = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
